// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: CPU port, host port and data-memory bus of the DM arbiter.
// slave = arbiter side, master = requesters/memory side. host_lock: DM_ARB_HOST_LOCK_EN.
interface dm_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
`ifdef DM_ARB_HOST_LOCK_EN
  logic              host_lock;
`endif

  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_write_data;
  logic              dm_write_enable;
  logic [DATA_W-1:0] dm_read_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
`ifdef DM_ARB_HOST_LOCK_EN
    input  host_lock,
`endif
    output host_ack, host_rdata, host_rvalid,
    output dm_address, dm_write_data, dm_write_enable,
    input  dm_read_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
`ifdef DM_ARB_HOST_LOCK_EN
    output host_lock,
`endif
    input  host_ack, host_rdata, host_rvalid,
    input  dm_address, dm_write_data, dm_write_enable,
    output dm_read_data
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares single-port data memory between CPU (C) and host (H).
// CPU priority with starvation counter; optional host lock via DM_ARB_HOST_LOCK_EN.
// Ports: clk, rst (sync, active high), bus (dm_arbiter_if.slave).
module dm_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
`ifdef DM_ARB_HOST_LOCK_EN
  ,
  parameter int LOCK_MAX     = 8
`endif
) (
  input  logic          clk,
  input  logic          rst,
  dm_arbiter_if.slave   bus
);

  logic             grant_c;
  logic             grant_h;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             lock_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic             host_rvalid_q;

  assign starve_hit = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_c = 1'b0;
    grant_h = 1'b0;
    if (rst) begin
      grant_c = 1'b0;
    end else if (lock_q && bus.host_req) begin
      grant_h = 1'b1;
    end else if (bus.cpu_req && bus.host_req) begin
      grant_h = starve_hit;
      grant_c = ~starve_hit;
    end else if (bus.cpu_req) begin
      grant_c = 1'b1;
    end else if (bus.host_req) begin
      grant_h = 1'b1;
    end
  end

  always_comb begin
    bus.dm_address      = '0;
    bus.dm_write_data   = '0;
    bus.dm_write_enable = 1'b0;
    unique case (1'b1)
      grant_c: begin
        bus.dm_address      = bus.cpu_addr;
        bus.dm_write_data   = bus.cpu_wdata;
        bus.dm_write_enable = bus.cpu_we;
      end
      grant_h: begin
        bus.dm_address      = bus.host_addr;
        bus.dm_write_data   = bus.host_wdata;
        bus.dm_write_enable = bus.host_we;
      end
      default: ;
    endcase
  end

  assign bus.cpu_rdata   = bus.dm_read_data;
  assign bus.cpu_stall   = bus.cpu_req & ~grant_c & ~rst;
  assign bus.host_ack    = grant_h;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;

  // Any cycle the host is not waiting resets its claim.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_h || !bus.host_req) begin
      starve_cnt <= '0;
    end else if (bus.cpu_req && !starve_hit) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else if (grant_h && !bus.host_we) begin
      host_rdata_q  <= bus.dm_read_data;
      host_rvalid_q <= 1'b1;
    end else begin
      host_rvalid_q <= 1'b0;
    end
  end

`ifdef DM_ARB_HOST_LOCK_EN
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_d;

  // Lock lapses after LOCK_MAX beats so a waiting CPU gets a slot.
  assign lock_d = grant_h & bus.host_lock &
                  (lock_cnt < CNT_W'(LOCK_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      lock_q <= lock_d;
      if (lock_d)
        lock_cnt <= lock_cnt + CNT_W'(1);
      else if (lock_q)
        lock_cnt <= '0;
    end
  end
`else
  assign lock_q = 1'b0;
`endif

endmodule
